// File: rtl/matmul_sched.sv
// Scheduler for a MAX_DIM x MAX_DIM output-stationary systolic array.
// Latches A, B and K on start, clears the array for one cycle, then streams
// skewed A rows / B columns into the array edges, waits one drain cycle and
// pulses done_o while the array holds the result.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start_i; array disabled
// S_CLEAR | one cycle with array enable low so accumulators clear
// S_FEED  | streaming skewed operands, feed index t = cnt_q
// S_DRAIN | one cycle of zero feeds so the last products settle
// S_DONE  | result valid for one cycle, done_o pulses
module matmul_sched #(
  parameter int DW      = 8,
  parameter int BW      = 32,
  parameter int MAX_DIM = BW / DW
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            start_i,
  input  logic                            abort_i,
  input  logic [1:0]                      dim_k_i,
  input  logic [MAX_DIM*MAX_DIM*DW-1:0]   mat_a_i,
  input  logic [MAX_DIM*MAX_DIM*DW-1:0]   mat_b_i,
  input  logic [MAX_DIM*MAX_DIM-1:0]      arr_of_i,
  output logic                            arr_start_o,
  output logic [MAX_DIM*DW-1:0]           arr_a_o,
  output logic [MAX_DIM*DW-1:0]           arr_b_o,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            of_any_o
);

  // Largest feed length is reached with K = 4 (dim_k_i = 3).
  localparam int FMAX = 4 + 2 * MAX_DIM - 2;
  localparam int CW   = $clog2(FMAX + 1);
  localparam int MW   = MAX_DIM * MAX_DIM * DW;
  localparam int FW   = MAX_DIM * DW;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cnt_last;
  logic [1:0]      k_q, k_d;
  logic [MW-1:0]   a_q, a_d, b_q, b_d;
  logic [FW-1:0]   fa_q, fa_d, fb_q, fb_d;
  logic            of_q, of_d;

  // Last feed index is F-1 = (K-1) + 2*MAX_DIM - 2.
  assign cnt_last = CW'(k_q) + CW'(2 * MAX_DIM - 2);

  // Next-state, operand latch, feed counter and sticky overflow.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    of_d    = of_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          state_d = S_CLEAR;
          a_d     = mat_a_i;
          b_d     = mat_b_i;
          k_d     = dim_k_i;
          of_d    = 1'b0;
        end
      end
      S_CLEAR: begin
        of_d = 1'b0;
        if (abort_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_FEED;
          cnt_d   = '0;
        end
      end
      S_FEED: begin
        of_d = of_q | (|arr_of_i);
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == cnt_last) begin
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DRAIN: begin
        of_d    = of_q | (|arr_of_i);
        state_d = abort_i ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        of_d    = of_q | (|arr_of_i);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Skewed feed values for the upcoming cycle, so they are registered
  // exactly when the FEED cycle with that index begins.
  always_comb begin
    fa_d = '0;
    fb_d = '0;
    if (state_d == S_FEED) begin
      for (int r = 0; r < MAX_DIM; r++) begin
        if ((int'(cnt_d) >= r) && (int'(cnt_d) - r <= int'(k_q)))
          fa_d[r*DW +: DW] = a_q[(r * MAX_DIM + int'(cnt_d) - r) * DW +: DW];
      end
      for (int c = 0; c < MAX_DIM; c++) begin
        if ((int'(cnt_d) >= c) && (int'(cnt_d) - c <= int'(k_q)))
          fb_d[c*DW +: DW] = b_q[((int'(cnt_d) - c) * MAX_DIM + c) * DW +: DW];
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      fa_q    <= '0;
      fb_q    <= '0;
      of_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      of_q    <= of_d;
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign arr_start_o = (state_q == S_FEED) || (state_q == S_DRAIN) || (state_q == S_DONE);
  assign arr_a_o     = fa_q;
  assign arr_b_o     = fb_q;
  assign of_any_o    = of_q;

endmodule

// File: tb/tb_matmul_sched.sv
// Bench for matmul_sched: drives runs with random operands, checks the
// skewed feeds per cycle against the index formula, and runs a small
// behavioural systolic array on the feeds whose result is compared with
// a plain matrix product.
module tb_matmul_sched;
  localparam int DW = 8;
  localparam int MD = 4;
  localparam int NN = MD * MD * DW;
  localparam int FW = MD * DW;

  logic          clk = 1'b0;
  logic          reset, start, abort;
  logic [1:0]    dim_k;
  logic [NN-1:0] mat_a, mat_b;
  logic [MD*MD-1:0] arr_of;
  logic          arr_start, busy, done, of_any;
  logic [FW-1:0] arr_a, arr_b;

  int n_pass  = 0;
  int n_total = 0;

  matmul_sched dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort),
    .dim_k_i(dim_k), .mat_a_i(mat_a), .mat_b_i(mat_b), .arr_of_i(arr_of),
    .arr_start_o(arr_start), .arr_a_o(arr_a), .arr_b_o(arr_b),
    .busy_o(busy), .done_o(done), .of_any_o(of_any)
  );

  always #5 clk = ~clk;

  // Behavioural output-stationary array fed from the scheduler outputs.
  logic [31:0] acc [MD][MD];
  logic [7:0]  ap  [MD][MD];
  logic [7:0]  bp  [MD][MD];

  function automatic logic [7:0] a_in(input int r, input int c);
    if (c == 0) return arr_a[r*DW +: DW];
    return ap[r][c-1];
  endfunction

  function automatic logic [7:0] b_in(input int r, input int c);
    if (r == 0) return arr_b[c*DW +: DW];
    return bp[r-1][c];
  endfunction

  always @(posedge clk) begin
    for (int r = 0; r < MD; r++) begin
      for (int c = 0; c < MD; c++) begin
        if (!arr_start) begin
          acc[r][c] <= '0;
          ap[r][c]  <= '0;
          bp[r][c]  <= '0;
        end else begin
          acc[r][c] <= acc[r][c] + 32'(a_in(r, c)) * 32'(b_in(r, c));
          ap[r][c]  <= a_in(r, c);
          bp[r][c]  <= b_in(r, c);
        end
      end
    end
  end

  function automatic logic [7:0] el(input logic [NN-1:0] m, input int r, input int c);
    return m[(r*MD + c)*DW +: DW];
  endfunction

  function automatic logic [NN-1:0] rnd_mat();
    logic [NN-1:0] m;
    for (int i = 0; i < NN / 32; i++) m[i*32 +: 32] = $urandom;
    return m;
  endfunction

  // Expected feed vectors for feed index t, from the skew rule.
  function automatic logic [FW-1:0] exp_fa(input logic [NN-1:0] a, input int kk, input int t);
    logic [FW-1:0] v = '0;
    for (int r = 0; r < MD; r++)
      if (t - r >= 0 && t - r < kk) v[r*DW +: DW] = el(a, r, t - r);
    return v;
  endfunction

  function automatic logic [FW-1:0] exp_fb(input logic [NN-1:0] b, input int kk, input int t);
    logic [FW-1:0] v = '0;
    for (int c = 0; c < MD; c++)
      if (t - c >= 0 && t - c < kk) v[c*DW +: DW] = el(b, t - c, c);
    return v;
  endfunction

  // One complete run from IDLE; of_t is the feed index with arr_of high (-1: none).
  task automatic run_and_check(input logic [NN-1:0] a, input logic [NN-1:0] b,
                               input logic [1:0] k, input int of_t);
    int kk = int'(k) + 1;
    int f  = kk + 2*MD - 2;
    int cyc;
    int done_cyc = -1;
    int err;
    int er, ec;
    logic [31:0] exp_v, got_v;
    logic [FW-1:0] ea, eb;
    @(negedge clk);
    mat_a = a; mat_b = b; dim_k = k; start = 1'b1;
    @(negedge clk);
    start = 1'b0; mat_a = rnd_mat(); mat_b = rnd_mat(); dim_k = 2'($urandom);
    cyc = 1;
    n_total++;
    if ({busy, arr_start, done, of_any, arr_a, arr_b} !== {1'b1, 1'b0, 1'b0, 1'b0, {2*FW{1'b0}}}) begin
      $display("FAIL clear_cycle: busy=%b start=%b done=%b of=%b a=%h b=%h, want busy=1 rest 0",
               busy, arr_start, done, of_any, arr_a, arr_b);
    end else n_pass++;
    while (done_cyc < 0 && cyc < f + 8) begin
      @(negedge clk);
      cyc++;
      arr_of = (cyc == of_t + 2) ? (16'h1 << $urandom_range(15)) : '0;
      ea = (cyc - 2 < f) ? exp_fa(a, kk, cyc - 2) : '0;
      eb = (cyc - 2 < f) ? exp_fb(b, kk, cyc - 2) : '0;
      n_total++;
      if ({busy, arr_start, arr_a, arr_b} !== {1'b1, 1'b1, ea, eb}) begin
        $display("FAIL feed cyc=%0d: busy=%b start=%b a=%h b=%h, want 1 1 a=%h b=%h",
                 cyc, busy, arr_start, arr_a, arr_b, ea, eb);
      end else n_pass++;
      if (done) begin
        done_cyc = cyc;
        err = 0; er = 0; ec = 0; exp_v = '0; got_v = '0;
        for (int r = 0; r < MD; r++) begin
          for (int c = 0; c < MD; c++) begin
            logic [31:0] s = '0;
            for (int i = 0; i < kk; i++) s += 32'(el(a, r, i)) * 32'(el(b, i, c));
            if (acc[r][c] !== s) begin
              if (err == 0) begin er = r; ec = c; exp_v = s; got_v = acc[r][c]; end
              err++;
            end
          end
        end
        n_total++;
        if (err != 0) $display("FAIL result: %0d wrong, C(%0d,%0d) got %0d want %0d",
                               err, er, ec, got_v, exp_v);
        else n_pass++;
        n_total++;
        if (of_any !== (of_t >= 0)) $display("FAIL of_any_at_done: got %b want %b", of_any, of_t >= 0);
        else n_pass++;
      end
    end
    arr_of = '0;
    n_total++;
    if (done_cyc != f + 3) $display("FAIL done_cycle: got %0d want %0d", done_cyc, f + 3);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({busy, arr_start, done, of_any, arr_a, arr_b} !== {3'b000, of_t >= 0, {2*FW{1'b0}}}) begin
      $display("FAIL after_done: busy=%b start=%b done=%b of=%b a=%h b=%h, want idle of=%b",
               busy, arr_start, done, of_any, arr_a, arr_b, of_t >= 0);
    end else n_pass++;
  endtask

  function automatic logic [NN-1:0] identity();
    logic [NN-1:0] m = '0;
    for (int i = 0; i < MD; i++) m[(i*MD + i)*DW +: DW] = 8'd1;
    return m;
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; abort = 1'b1; dim_k = 2'd3;
    mat_a = rnd_mat(); mat_b = rnd_mat(); arr_of = '1;
    repeat (3) @(negedge clk);
    n_total++;
    if ({busy, done, arr_start, of_any, arr_a, arr_b} !== '0)
      $display("FAIL reset_state: busy=%b done=%b start=%b of=%b a=%h b=%h, want all 0",
               busy, done, arr_start, of_any, arr_a, arr_b);
    else n_pass++;
    reset = 1'b0; start = 1'b0; abort = 1'b0; arr_of = '0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({busy, done, arr_start, of_any} !== 4'b0)
      $display("FAIL idle_after_reset: busy=%b done=%b start=%b of=%b, want 0", busy, done, arr_start, of_any);
    else n_pass++;
  endtask

  task automatic test_identity();
    run_and_check(identity(), identity(), 2'd3, -1);
  endtask

  task automatic test_k1();
    logic [NN-1:0] a = rnd_mat();
    logic [NN-1:0] b = rnd_mat();
    for (int i = 0; i < MD; i++) begin
      a[(i*MD)*DW +: DW] = 8'(i + 1);
      b[i*DW +: DW]      = 8'(i + 5);
    end
    run_and_check(a, b, 2'd0, -1);
  endtask

  task automatic test_start_held();
    logic exp_done, exp_busy;
    int waited = 0;
    @(negedge clk);
    mat_a = identity(); mat_b = identity(); dim_k = 2'd3; start = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (cyc > 0) @(negedge clk);
      exp_done = (cyc == 13) || (cyc == 27);
      exp_busy = !((cyc == 0) || (cyc == 14) || (cyc == 28));
      n_total++;
      if ({done, busy} !== {exp_done, exp_busy})
        $display("FAIL held_start cyc=%0d: done=%b busy=%b, want %b %b", cyc, done, busy, exp_done, exp_busy);
      else n_pass++;
    end
    start = 1'b0;
    while (busy && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    n_total++;
    if (busy !== 1'b0) $display("FAIL held_start_drain: busy=%b, want 0", busy);
    else n_pass++;
  endtask

  task automatic test_abort();
    int saw_done = 0;
    @(negedge clk);
    mat_a = rnd_mat(); mat_b = rnd_mat(); dim_k = 2'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);  // now in cycle 5, FEED t=3
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_total++;
    if ({busy, arr_start, done, arr_a, arr_b} !== '0)
      $display("FAIL abort_next: busy=%b start=%b done=%b a=%h b=%h, want all 0",
               busy, arr_start, done, arr_a, arr_b);
    else n_pass++;
    repeat (15) begin
      @(negedge clk);
      if (done) saw_done++;
    end
    n_total++;
    if (saw_done != 0) $display("FAIL abort_no_done: got %0d pulses want 0", saw_done);
    else n_pass++;
    run_and_check(rnd_mat(), rnd_mat(), 2'($urandom), -1);
  endtask

  task automatic test_reset_mid();
    int saw_done = 0;
    @(negedge clk);
    mat_a = rnd_mat(); mat_b = rnd_mat(); dim_k = 2'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);  // cycle 4, FEED t=2
    arr_of = 16'h0100;
    @(negedge clk);
    arr_of = '0;
    repeat (2) @(negedge clk);  // cycle 7, FEED t=5
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_total++;
    if ({busy, arr_start, done, of_any, arr_a, arr_b} !== '0)
      $display("FAIL reset_mid: busy=%b start=%b done=%b of=%b a=%h b=%h, want all 0",
               busy, arr_start, done, of_any, arr_a, arr_b);
    else n_pass++;
    repeat (15) begin
      @(negedge clk);
      if (done) saw_done++;
    end
    n_total++;
    if (saw_done != 0) $display("FAIL reset_no_done: got %0d pulses want 0", saw_done);
    else n_pass++;
    run_and_check(rnd_mat(), rnd_mat(), 2'd2, -1);
  endtask

  task automatic test_overflow();
    run_and_check('1, '1, 2'd3, 2);
    run_and_check(rnd_mat(), rnd_mat(), 2'd1, -1);
  endtask

  task automatic test_random();
    logic [1:0] k;
    int of_t;
    for (int n = 0; n < 8; n++) begin
      k = 2'($urandom);
      of_t = ($urandom_range(1) == 1) ? $urandom_range(int'(k) + 2*MD - 2) : -1;
      run_and_check(rnd_mat(), rnd_mat(), k, of_t);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; dim_k = '0;
    mat_a = '0; mat_b = '0; arr_of = '0;
    test_reset();
    test_identity();
    test_k1();
    test_start_held();
    test_abort();
    test_reset_mid();
    test_overflow();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
